// File: rtl/seq_div_if.sv
// seq_div_if -- handshake and operand/result bundle for the sequential divider.
//
// Parameters:
//   DW_N : dividend / quotient width.
//   DW_D : divisor / remainder width.
//
// Signals:
//   start     : request (pulse or level) from the master.
//   dividend  : unsigned dividend operand.
//   divisor   : unsigned divisor operand.
//   busy      : division in progress.
//   done      : one-cycle pulse, results valid.
//   quotient  : registered quotient, held until the next done.
//   remainder : registered remainder, held until the next done.
//   div_zero  : divisor was zero (only meaningful with DIV_ZERO_CHK_EN).
//
// Modports:
//   master : drives start and the operands, observes the results.
//   slave  : the divider itself.
interface seq_div_if #(
    parameter int DW_N = 8,
    parameter int DW_D = 4
);
    logic            start;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            busy;
    logic            done;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_div.sv
// seq_div -- sequential restoring divider, one quotient bit per clock.
//
// An unsigned DW_N-bit dividend is divided by a DW_D-bit divisor, giving a
// DW_N-bit quotient and a DW_D-bit remainder (dividend = q*divisor + r).
//
// Ports:
//   clk : system clock, all state on the rising edge.
//   rst : asynchronous, active-high reset.
//   bus : seq_div_if.slave -- start/dividend/divisor in,
//         busy/done/quotient/remainder/div_zero out.
//
// Macro DIV_ZERO_CHK_EN:
//   defined   -> a zero divisor skips the iterations; the result (quotient all
//                ones, remainder = dividend[DW_D-1:0], div_zero=1) is issued
//                with done one edge after acceptance.
//   undefined -> no zero detect, div_zero tied 0; a zero divisor runs the
//                normal path, which naturally yields the same quotient and
//                remainder.
//
// Timing (start accepted at edge E0): iterations on E1..E(DW_N), results and
// done written at E(DW_N+1), done drops one edge later. A new start is taken
// only in IDLE with done low, so held-high start repeats every DW_N+3 cycles.
module seq_div #(
    parameter int DW_N = 8,
    parameter int DW_D = 4
) (
    input  logic      clk,
    input  logic      rst,
    seq_div_if.slave  bus
);
    localparam int CW = (DW_N > 1) ? $clog2(DW_N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [DW_N-1:0] shift_reg;   // dividend bits out of the MSB, quotient bits in at the LSB
    logic [DW_D-1:0] dvs_reg;
    logic [DW_D:0]   part_reg;    // partial remainder P
    logic            busy_reg;
    logic            done_reg;
    logic [DW_N-1:0] quo_reg;
    logic [DW_D-1:0] rem_reg;
`ifdef DIV_ZERO_CHK_EN
    logic            zero_reg;
    logic            div_zero_reg;
`endif

    // One restoring step: shift the next dividend bit into P and subtract
    // the divisor when it fits.
    logic [DW_D:0] trial_next;
    logic [DW_D:0] part_next;
    logic          qbit_next;

    always_comb begin
        trial_next = {part_reg[DW_D-1:0], shift_reg[DW_N-1]};
        qbit_next  = (trial_next >= {1'b0, dvs_reg});
        part_next  = qbit_next ? (trial_next - {1'b0, dvs_reg}) : trial_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            dvs_reg      <= '0;
            part_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            quo_reg      <= '0;
            rem_reg      <= '0;
`ifdef DIV_ZERO_CHK_EN
            zero_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    // While done is still high the results are being
                    // presented; acceptance waits one cycle so every
                    // division starts from a quiet IDLE cycle.
                    if (bus.start && !done_reg) begin
                        shift_reg <= bus.dividend;
                        dvs_reg   <= bus.divisor;
                        part_reg  <= '0;
                        cnt_reg   <= CNT_LOAD;
                        busy_reg  <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
                        zero_reg  <= (bus.divisor == '0);
                        state_reg <= (bus.divisor == '0) ? DONE : CALC;
`else
                        state_reg <= CALC;
`endif
                    end
                end

                CALC: begin
                    part_reg  <= part_next;
                    shift_reg <= {shift_reg[DW_N-2:0], qbit_next};
                    cnt_reg   <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
`ifdef DIV_ZERO_CHK_EN
                    if (zero_reg) begin
                        // No iterations ran, so shift_reg still holds the dividend.
                        quo_reg      <= '1;
                        rem_reg      <= shift_reg[DW_D-1:0];
                        div_zero_reg <= 1'b1;
                    end else begin
                        quo_reg      <= shift_reg;
                        rem_reg      <= part_reg[DW_D-1:0];
                        div_zero_reg <= 1'b0;
                    end
`else
                    quo_reg <= shift_reg;
                    rem_reg <= part_reg[DW_D-1:0];
`endif
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quo_reg;
    assign bus.remainder = rem_reg;
`ifdef DIV_ZERO_CHK_EN
    assign bus.div_zero  = div_zero_reg;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div -- self-checking bench for seq_div (DW_N=8, DW_D=4).
// Table-driven vectors, hand-written multi-cycle sequences (operand change
// during CALC, mid-division reset, held start) and random operands checked
// against an arithmetic reference model.
module tb_seq_div;
    localparam int DW_N = 8;
    localparam int DW_D = 4;
    localparam int LAT  = DW_N + 1;
`ifdef DIV_ZERO_CHK_EN
    localparam int ZCHK = 1;
`else
    localparam int ZCHK = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_if #(.DW_N(DW_N), .DW_D(DW_D)) bus ();

    seq_div #(.DW_N(DW_N), .DW_D(DW_D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
        int lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic model(input int a, input int b, output int q, output int r,
                         output int z, output int lat);
        if (b == 0) begin
            q   = (1 << DW_N) - 1;
            r   = a % (1 << DW_D);
            z   = ZCHK;
            lat = (ZCHK != 0) ? 1 : LAT;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = 0;
            lat = LAT;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%0d done=%0d expected idle", bus.busy, bus.done);
        end
    endtask

    task automatic run_div(input string tag, input int a, input int b, input int eq,
                           input int er, input int ez, input int elat);
        int n = 0;
        int busy_n = 0;
        wait_idle();
        bus.dividend = DW_N'(a);
        bus.divisor  = DW_D'(b);
        bus.start    = 1'b1;
        step();                       // E0
        bus.start    = 1'b0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            step();
            n++;
        end
        check({tag, " latency"}, n, elat);
        check({tag, " busy_cycles"}, busy_n, elat);
        check({tag, " busy_at_done"}, bus.busy, 0);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_zero"}, bus.div_zero, ez);
        $display("%s: %0d/%0d -> q=%0d r=%0d z=%0d lat=%0d", tag, a, b,
                 bus.quotient, bus.remainder, bus.div_zero, n);
    endtask

    initial begin
        vec_t vecs[$];
        int q, r, z, lat, n, busy_n, prev, dcnt;

        vecs.push_back('{200, 7, 28, 4, 0, LAT});
        vecs.push_back('{255, 15, 17, 0, 0, LAT});
        vecs.push_back('{5, 9, 0, 5, 0, LAT});
        vecs.push_back('{'hA6, 0, 'hFF, 6, ZCHK, (ZCHK != 0) ? 1 : LAT});
        vecs.push_back('{9, 2, 4, 1, 0, LAT});
        vecs.push_back('{0, 1, 0, 0, 0, LAT});
        vecs.push_back('{255, 1, 255, 0, 0, LAT});
        vecs.push_back('{77, 5, 15, 2, 0, LAT});
        vecs.push_back('{14, 15, 0, 14, 0, LAT});   // follows a zero-result run? no: checks r = divisor-1

        // Reset state
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        step();
        step();
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset quotient", bus.quotient, 0);
        check("reset remainder", bus.remainder, 0);
        check("reset div_zero", bus.div_zero, 0);
        $display("reset: busy=%0d done=%0d q=%0d r=%0d", bus.busy, bus.done, bus.quotient, bus.remainder);
        rst = 1'b0;
        step();

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
                    vecs[i].r, vecs[i].z, vecs[i].lat);
        end

        // Zero divisor followed by a nonzero one clears div_zero
        run_div("zero_then", 'h3C, 0, 'hFF, 'hC, ZCHK, (ZCHK != 0) ? 1 : LAT);
        run_div("nonzero_after", 50, 6, 8, 2, 0, LAT);

        // Operands changed and start pulsed during CALC of 100/3
        wait_idle();
        bus.dividend = 8'd100;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        step();                       // E0
        bus.start    = 1'b0;
        bus.dividend = 8'd1;
        bus.divisor  = 4'd1;
        n = 0;
        busy_n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            bus.start = (n == 2 || n == 5);
            step();
            n++;
        end
        bus.start = 1'b0;
        check("calc_change latency", n, LAT);
        check("calc_change busy_cycles", busy_n, LAT);
        check("calc_change quotient", bus.quotient, 33);
        check("calc_change remainder", bus.remainder, 1);
        $display("calc_change: 100/3 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, n);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done || bus.busy) dcnt++;
        end
        check("calc_change no_second_run", dcnt, 0);

        // Reset pulsed at E4 of 200/7
        wait_idle();
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        step();                       // E0
        bus.start    = 1'b0;
        step();
        step();
        step();                       // E3
        @(posedge clk);               // E4
        rst = 1'b1;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst quotient", bus.quotient, 0);
        check("midrst remainder", bus.remainder, 0);
        check("midrst div_zero", bus.div_zero, 0);
        $display("midrst: busy=%0d q=%0d r=%0d", bus.busy, bus.quotient, bus.remainder);
        step();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.done) dcnt++;
        end
        check("midrst no_done", dcnt, 0);
        run_div("after_rst", 9, 2, 4, 1, 0, LAT);

        // start held high: back-to-back 77/5
        wait_idle();
        bus.dividend = 8'd77;
        bus.divisor  = 4'd5;
        bus.start    = 1'b1;
        prev = -1;
        dcnt = 0;
        for (int i = 0; i < 34; i++) begin
            step();                   // edge E_i of the first division
            if (bus.done) begin
                check("held quotient", bus.quotient, 15);
                check("held remainder", bus.remainder, 2);
                if (prev >= 0) check("held spacing", i - prev, LAT + 2);
                else check("held first_done", i, LAT);
                $display("held: done at cycle %0d q=%0d r=%0d", i, bus.quotient, bus.remainder);
                prev = i;
                dcnt++;
            end
        end
        bus.start = 1'b0;
        check("held done_count", dcnt, 3);

        // Random operands against the model
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << DW_N) - 1));
            b = int'($urandom_range(0, (1 << DW_D) - 1));
            model(a, b, q, r, z, lat);
            run_div($sformatf("rnd%0d", i), a, b, q, r, z, lat);
        end

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
